// File: rtl/mem_copy_engine_if.sv
// Memory-side bus of the word copier: byte address, write strobe/data and async read data.
// The engine is the master; the single-port memory is the slave.
interface mem_copy_engine_if;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/mem_copy_engine.sv
// DMA-style word copier: moves len 32-bit words from src_addr to dst_addr, one read
// cycle then one write cycle per word, and pulses done (with err on misalignment).
module mem_copy_engine #(
    parameter int LEN_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg,
    mem_copy_engine_if.master mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] count;
    logic [31:0]      data_reg;
    logic [31:0]      addr_q;
    logic             wr_en_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Handshake: start is honoured only in IDLE (a one-cycle request; it is neither
    // queued nor acknowledged while busy). Completion is the one-cycle done pulse,
    // qualified by err; busy covers every cycle from the start edge to the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            state  <= FIN;
                        end else if (len == '0) begin
                            done_q <= 1'b1;
                            state  <= FIN;
                        end else begin
                            src_ptr <= src_addr;
                            dst_ptr <= dst_addr;
                            count   <= len;
                            addr_q  <= src_addr;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    data_reg <= mem.mem_rd_data;
                    addr_q   <= dst_ptr;
                    wr_en_q  <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    // The memory commits the word on this edge; advance to the next one.
                    wr_en_q <= 1'b0;
                    src_ptr <= src_ptr + 32'd4;
                    dst_ptr <= dst_ptr + 32'd4;
                    count   <= count - LEN_W'(1);
                    if (count == LEN_W'(1)) begin
                        addr_q <= '0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        addr_q <= src_ptr + 32'd4;
                        state  <= READ;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign state_dbg       = state;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_wr_data = data_reg;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: 1024-word memory model, directed and random copy jobs
// checked against a word-by-word forward-copy reference of the memory image.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [9:0]  len = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  mem_copy_engine_if bus ();

  mem_copy_engine #(.LEN_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg),
    .mem       (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory: async read, sync write; tb_we is a preload port used only while the DUT idles
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_idx = '0;
  logic [31:0] tb_data = '0;
  int unsigned wr_cycles = 0;

  assign bus.mem_rd_data = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (tb_we) mem[tb_idx] <= tb_data;
    else if (bus.mem_wr_en) mem[bus.mem_addr[11:2]] <= bus.mem_wr_data;
  end

  always @(posedge clk) if (bus.mem_wr_en) wr_cycles++;

  // scoreboard
  logic [31:0] exp_q [$];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    tb_we = 1'b1;
    tb_idx = 10'(idx);
    tb_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [9:0] n,
                         input bit glitch);
    int cycles;
    int exp_cycles;
    int unsigned wr0;
    logic [31:0] a;
    logic [31:0] wd;
    bit bad;
    bad = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    exp_q.delete();
    wa_q.delete();
    wd_q.delete();
    if (!bad) begin
      for (int i = 0; i < int'(n); i++) begin
        a = s + 32'(4 * i);
        exp_q.push_back(a);
        wd = ref_mem[a[11:2]];
        a = d + 32'(4 * i);
        wa_q.push_back(a);
        wd_q.push_back(wd);
        ref_mem[a[11:2]] = wd;
      end
    end
    exp_cycles = bad ? 1 : 2 * int'(n) + 1;

    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = n;
    start = 1'b1;
    wr0 = wr_cycles;
    @(negedge clk);
    start = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len = 10'($urandom);
    cycles = 1;
    while (!done && cycles < 5000) begin
      if (bus.mem_wr_en) begin
        if (wa_q.size() == 0) check("extra_write", 32'(1), 32'(0));
        else begin
          check("wr_addr", bus.mem_addr, wa_q.pop_front());
          check("wr_data", bus.mem_wr_data, wd_q.pop_front());
        end
      end else if (busy) begin
        if (exp_q.size() == 0) check("extra_read", 32'(1), 32'(0));
        else check("rd_addr", bus.mem_addr, exp_q.pop_front());
      end
      start = (glitch && cycles == 2) ? 1'b1 : 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = glitch ? 1'b1 : 1'b0;
    check("done_seen", 32'(done), 32'(1));
    check("cycles_to_done", 32'(cycles), 32'(exp_cycles));
    check("err_flag", 32'(err), 32'(bad));
    check("busy_at_done", 32'(busy), 32'(1));
    check("wr_en_at_done", 32'(bus.mem_wr_en), 32'(0));
    check("reads_left", 32'(exp_q.size()), 32'(0));
    check("writes_left", 32'(wa_q.size()), 32'(0));
    @(negedge clk);
    start = 1'b0;
    check("busy_after", 32'(busy), 32'(0));
    check("done_after", 32'(done), 32'(0));
    check("err_after", 32'(err), 32'(0));
    check("state_after", 32'(state_dbg), 32'(0));
    check("write_cycles", 32'(wr_cycles - wr0), bad ? 32'(0) : 32'(n));
  endtask

  initial begin
    logic [31:0] rs;
    logic [31:0] rd;
    int mism;

    // reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'(0));
    check("rst_addr", bus.mem_addr, 32'(0));
    check("rst_wr_data", bus.mem_wr_data, 32'(0));
    check("rst_state", 32'(state_dbg), 32'(0));

    // preload whole memory with random words
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      tb_we = 1'b1;
      tb_idx = 10'(i);
      tb_data = $urandom;
      ref_mem[i] = tb_data;
    end
    @(negedge clk);
    tb_we = 1'b0;
    reset = 1'b0;

    // basic 4-word copy
    for (int i = 0; i < 4; i++) poke(i, 32'hA0A0_0000 + 32'(i));
    run_job(32'h0, 32'h100, 10'd4, 1'b0);
    check("t1_word3", mem[67], 32'hA0A0_0003);

    // zero length, misaligned source, misaligned destination
    run_job(32'h40, 32'h80, 10'd0, 1'b0);
    run_job(32'h2, 32'h100, 10'd3, 1'b0);
    run_job(32'h10, 32'h101, 10'd2, 1'b0);

    // overlapping forward smear with a start pulse mid-job
    poke(0, 32'hDEAD_BEEF);
    run_job(32'h0, 32'h4, 10'd3, 1'b1);
    check("smear_word3", mem[3], 32'hDEAD_BEEF);

    // address wrap
    run_job(32'hFFC, 32'h200, 10'd1, 1'b0);
    run_job(32'hFFFF_FFFC, 32'h240, 10'd2, 1'b0);

    // reset during the second write of a 4-word job
    @(negedge clk);
    src_addr = 32'h400;
    dst_addr = 32'h500;
    len = 10'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t6_in_write", 32'(bus.mem_wr_en), 32'(1));
    check("t6_write_addr", bus.mem_addr, 32'h504);
    reset = 1'b1;
    #1;
    check("t6_wr_en_async", 32'(bus.mem_wr_en), 32'(0));
    check("t6_busy_async", 32'(busy), 32'(0));
    check("t6_done_async", 32'(done), 32'(0));
    check("t6_addr_async", bus.mem_addr, 32'(0));
    check("t6_state_async", 32'(state_dbg), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    check("t6_done_none", 32'(done), 32'(0));
    ref_mem[32'h500 >> 2] = ref_mem[32'h400 >> 2];
    check("t6_word0", mem[32'h500 >> 2], ref_mem[32'h400 >> 2]);
    check("t6_word1_kept", mem[32'h504 >> 2], ref_mem[32'h504 >> 2]);
    run_job(32'h400, 32'h500, 10'd4, 1'b0);

    // random jobs
    for (int j = 0; j < 24; j++) begin
      rs = 32'($urandom_range(0, 1023)) * 32'd4;
      rd = 32'($urandom_range(0, 1023)) * 32'd4;
      if ($urandom_range(0, 3) == 0) rs = rs | 32'hFFFF_F000;
      if ($urandom_range(0, 7) == 0) rs = rs | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rd = rd | 32'($urandom_range(1, 3));
      run_job(rs, rd, 10'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end

    // final memory image
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("mem_image", 32'(mism), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
